alu_ctrl_fsm: RTL and testbench
===============================

# alu_ctrl_fsm

Multi-cycle instruction control unit that drives the 8-bit ALU: it accepts 32-bit instruction words from fetch over a valid/ready handshake, decodes them, reads the register file, presents operands and SELECT to the ALU, and holds them for the ALU's settle time. It then issues a single-cycle register writeback or branch request. It sits between instruction fetch and the ALU/register-file datapath.

## Interface
- ADD_WAIT, default 2: EXEC cycles for add/sub/beq/bne (ALU adder settle).
- LOGIC_WAIT, default 1: EXEC cycles for all other ALU ops; must be ≥1.
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- INSTR_VALID  in  1  fetch has an instruction.
- INSTR  in  32  OP[31:24], DEST[18:16], SRC1[10:8], SRC2[2:0], IMM[7:0]; DEST field [23:16] doubles as signed branch offset.
- INSTR_READY  out  1  block can accept an instruction.
- READREG1 / READREG2  out  3  register-file read addresses (SRC1 / SRC2).
- REGOUT1 / REGOUT2  in  8  register-file read data, combinational.
- ALUOP  out  3  to ALU SELECT.
- OPERAND1 / OPERAND2  out  8  to ALU DATA1 / DATA2.
- RESULT  in  8, ZERO  in  1  from ALU.
- WRITEREG  out  3, WRITEDATA  out  8, WRITEENABLE  out  1  register writeback.
- BRANCH  out  1, BRANCH_OFFSET  out  8  one-cycle PC redirect request.
- ILLEGAL  out  1  one-cycle pulse on an undecodable opcode.

## Operation
- Opcodes: 0 loadi, 1 mov, 2 add, 3 sub, 4 and, 5 or, 6 j, 7 beq, 8 sll, 9 srl, 10 sra, 11 ror, 12 bne; 13–255 are illegal.
- ALUOP: loadi/mov 000; add/sub/beq/bne 001; and 010; or 011; sll 100; srl 101; sra 110; ror 111.
- OPERAND1 = REGOUT1 for all ops; 0 for loadi/mov/j.
- OPERAND2: loadi and shifts → IMM; mov/add/and/or → REGOUT2; sub/beq/bne → (~REGOUT2 + 1) mod 256 (0x00→0x00, 0x80→0x80).
- ALU writeback ops (loadi, mov, add, sub, and, or, shifts): WRITEREG = DEST, WRITEDATA = RESULT sampled on the last EXEC edge.
- beq: BRANCH if sampled ZERO = 1. bne: BRANCH if ZERO = 0. j: BRANCH unconditionally, no ALU wait. BRANCH_OFFSET = INSTR[23:16]. Branches never write back.
- Illegal opcode: ILLEGAL pulse in WB; no writeback, no branch.
- States: IDLE → (VALID & READY) → DECODE → EXEC (ADD_WAIT or LOGIC_WAIT cycles; j skips EXEC) → WB → IDLE.
- The instruction is latched on accept. READREG1/2, ALUOP and OPERAND1/2 are registered and stable from the DECODE→EXEC edge through the end of WB.

## Timing
- Reset values: INSTR_READY 0, ALUOP 000, OPERAND1/2 0x00, READREG1/2 0, WRITEREG 0, WRITEDATA 0x00, WRITEENABLE 0, BRANCH 0, BRANCH_OFFSET 0x00, ILLEGAL 0; state IDLE.
- INSTR_READY is registered. It goes to 1 on the first rising edge after RESET_N deasserts, is high only in IDLE, and drops on the accept edge.
- Accept on edge t. WB is asserted in cycle t+3 for 1-wait ops, t+4 for 2-wait ops, and t+2 for j.
- INSTR_READY returns 1 the cycle after WB. There are no back-to-back accepts.
- WRITEENABLE, BRANCH and ILLEGAL are each exactly one cycle wide and mutually exclusive.
- INSTR_VALID high while not ready: ignored. INSTR may change freely when not accepted.
- RESET_N asserted mid-instruction: immediate abort, all outputs to reset values, and no partial writeback or branch.

## Configuration
- ALU_CTRL_SHIFT_EN defined: opcodes 8–11 decode as specified.
- ALU_CTRL_SHIFT_EN undefined: opcodes 8–11 are illegal (ILLEGAL pulse), and ALUOP never takes values 1xx.

## Structure
- Package alu_ctrl_pkg holds the opcode constants, ALUOP constants, instruction field positions, and the state enum (IDLE, DECODE, EXEC, WB).
- Sub-module ctrl_operand_sel is combinational: it takes opcode, REGOUT1/2 and IMM, and produces OPERAND1/2 including two's-complement negation. The FSM registers its outputs.

## Test plan
- Reset, then loadi r2,0x2A → WRITEENABLE pulse at t+3 with WRITEREG 2, WRITEDATA 0x2A, ALUOP 000.
- add r3,r1,r2 with r1=0x05, r2=0x0A → OPERAND2 0x0A held 2 EXEC cycles, WRITEDATA 0x0F at t+4.
- sub with REGOUT2=0x01 → OPERAND2 0xFF. beq with equal regs (ZERO=1) and offset 0xFE → BRANCH pulse with BRANCH_OFFSET 0xFE and no WRITEENABLE.
- sll r1,r1,3 with r1=0x11 → ALUOP 100, OPERAND2 0x03, WRITEDATA 0x88. Rebuilt without ALU_CTRL_SHIFT_EN → ILLEGAL pulse only.
- Opcode 0xFF → ILLEGAL pulse at t+3 and INSTR_READY high at t+4. INSTR_VALID held high throughout → exactly one accept per IDLE visit.
- RESET_N pulled low during EXEC of add → no WRITEENABLE, all outputs at reset values. After release, INSTR_READY is 1 one edge later.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared opcode/ALUOP encodings, instruction field positions, FSM state type and decoder.
// Build option ALU_CTRL_SHIFT_EN makes opcodes 8-11 (sll/srl/sra/ror) legal.
package alu_ctrl_pkg;

    localparam logic [7:0] OP_LOADI = 8'd0;
    localparam logic [7:0] OP_MOV   = 8'd1;
    localparam logic [7:0] OP_ADD   = 8'd2;
    localparam logic [7:0] OP_SUB   = 8'd3;
    localparam logic [7:0] OP_AND   = 8'd4;
    localparam logic [7:0] OP_OR    = 8'd5;
    localparam logic [7:0] OP_J     = 8'd6;
    localparam logic [7:0] OP_BEQ   = 8'd7;
    localparam logic [7:0] OP_SLL   = 8'd8;
    localparam logic [7:0] OP_SRL   = 8'd9;
    localparam logic [7:0] OP_SRA   = 8'd10;
    localparam logic [7:0] OP_ROR   = 8'd11;
    localparam logic [7:0] OP_BNE   = 8'd12;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_SRA  = 3'b110;
    localparam logic [2:0] ALU_ROR  = 3'b111;

    localparam int F_OP_LO   = 24;
    localparam int F_HI_LO   = 16;  // DEST in low 3 bits, or signed branch offset
    localparam int F_SRC1_LO = 8;
    localparam int F_SRC2_LO = 0;
    localparam int F_IMM_LO  = 0;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       writes;
        logic       cond_br;
        logic       br_on_zero;
        logic       jump;
        logic       illegal;
        logic       long_wait;
    } decode_t;

    function automatic logic [7:0] negate8(input logic [7:0] x);
        return ~x + 8'd1;
    endfunction

    function automatic decode_t decode_op(input logic [7:0] op);
        decode_t d;
        d = '0;
        d.aluop = ALU_PASS;
        case (op)
            OP_LOADI, OP_MOV: d.writes = 1'b1;
            OP_ADD, OP_SUB: begin
                d.aluop = ALU_ADD; d.writes = 1'b1; d.long_wait = 1'b1;
            end
            OP_AND: begin d.aluop = ALU_AND; d.writes = 1'b1; end
            OP_OR:  begin d.aluop = ALU_OR;  d.writes = 1'b1; end
            OP_J:   d.jump = 1'b1;
            OP_BEQ: begin
                d.aluop = ALU_ADD; d.cond_br = 1'b1; d.br_on_zero = 1'b1; d.long_wait = 1'b1;
            end
            OP_BNE: begin
                d.aluop = ALU_ADD; d.cond_br = 1'b1; d.long_wait = 1'b1;
            end
`ifdef ALU_CTRL_SHIFT_EN
            OP_SLL: begin d.aluop = ALU_SLL; d.writes = 1'b1; end
            OP_SRL: begin d.aluop = ALU_SRL; d.writes = 1'b1; end
            OP_SRA: begin d.aluop = ALU_SRA; d.writes = 1'b1; end
            OP_ROR: begin d.aluop = ALU_ROR; d.writes = 1'b1; end
`endif
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Bundle of fetch handshake, register-file, ALU and writeback/branch signals around the controller.
interface alu_ctrl_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [2:0]  readreg1;
    logic [2:0]  readreg2;
    logic [7:0]  regout1;
    logic [7:0]  regout2;
    logic [2:0]  aluop;
    logic [7:0]  operand1;
    logic [7:0]  operand2;
    logic [7:0]  result;
    logic        zero;
    logic [2:0]  writereg;
    logic [7:0]  writedata;
    logic        writeenable;
    logic        branch;
    logic [7:0]  branch_offset;
    logic        illegal;

    modport master (
        input  instr_valid, instr, regout1, regout2, result, zero,
        output instr_ready, readreg1, readreg2, aluop, operand1, operand2,
               writereg, writedata, writeenable, branch, branch_offset, illegal
    );

    modport slave (
        output instr_valid, instr, regout1, regout2, result, zero,
        input  instr_ready, readreg1, readreg2, aluop, operand1, operand2,
               writereg, writedata, writeenable, branch, branch_offset, illegal
    );
endinterface

// File: rtl/ctrl_operand_sel.sv
// Combinational ALU operand selection; subtract-style ops get the two's-complement of REGOUT2.
module ctrl_operand_sel
    import alu_ctrl_pkg::*;
(
    input  logic [7:0] op,
    input  logic [7:0] regout1,
    input  logic [7:0] regout2,
    input  logic [7:0] imm,
    output logic [7:0] operand1,
    output logic [7:0] operand2
);
    always_comb begin
        operand1 = regout1;
        operand2 = regout2;
        case (op)
            OP_LOADI: begin operand1 = '0; operand2 = imm; end
            OP_MOV:   operand1 = '0;
            OP_J:     begin operand1 = '0; operand2 = '0; end
            OP_SUB, OP_BEQ, OP_BNE: operand2 = negate8(regout2);
            OP_SLL, OP_SRL, OP_SRA, OP_ROR: operand2 = imm;
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle instruction controller: accept, decode/read regs, hold ALU inputs, one-cycle writeback/branch.
// Shift opcodes are legal only when built with ALU_CTRL_SHIFT_EN (see alu_ctrl_pkg).
module alu_ctrl_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int ADD_WAIT   = 2,
    parameter int LOGIC_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_ctrl_if.master bus
);
    localparam logic [7:0] ADD_WAIT_M1   = 8'(ADD_WAIT - 1);
    localparam logic [7:0] LOGIC_WAIT_M1 = 8'(LOGIC_WAIT - 1);

    state_t     state_reg, state_next;
    logic [7:0] op_reg, op_next;
    logic [7:0] hi_reg, hi_next;
    logic [7:0] imm_reg, imm_next;
    logic [7:0] wait_reg, wait_next;
    logic       ready_reg, ready_next;
    logic [2:0] readreg1_reg, readreg1_next;
    logic [2:0] readreg2_reg, readreg2_next;
    logic [2:0] aluop_reg, aluop_next;
    logic [7:0] operand1_reg, operand1_next;
    logic [7:0] operand2_reg, operand2_next;
    logic [2:0] writereg_reg, writereg_next;
    logic [7:0] writedata_reg, writedata_next;
    logic       we_reg, we_next;
    logic       branch_reg, branch_next;
    logic [7:0] boff_reg, boff_next;
    logic       illegal_reg, illegal_next;

    decode_t    dec;
    logic [7:0] sel_op1, sel_op2;
    logic       accept;

    assign dec = decode_op(op_reg);

    ctrl_operand_sel u_operand_sel (
        .op       (op_reg),
        .regout1  (bus.regout1),
        .regout2  (bus.regout2),
        .imm      (imm_reg),
        .operand1 (sel_op1),
        .operand2 (sel_op2)
    );

    assign accept = (state_reg == IDLE) && ready_reg && bus.instr_valid;

    always_comb begin
        state_next     = state_reg;
        op_next        = op_reg;
        hi_next        = hi_reg;
        imm_next       = imm_reg;
        wait_next      = wait_reg;
        readreg1_next  = readreg1_reg;
        readreg2_next  = readreg2_reg;
        aluop_next     = aluop_reg;
        operand1_next  = operand1_reg;
        operand2_next  = operand2_reg;
        writereg_next  = writereg_reg;
        writedata_next = writedata_reg;
        boff_next      = boff_reg;
        we_next        = 1'b0;
        branch_next    = 1'b0;
        illegal_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    op_next       = bus.instr[F_OP_LO +: 8];
                    hi_next       = bus.instr[F_HI_LO +: 8];
                    imm_next      = bus.instr[F_IMM_LO +: 8];
                    // Read addresses go out during DECODE so REGOUT is valid at the operand edge
                    readreg1_next = bus.instr[F_SRC1_LO +: 3];
                    readreg2_next = bus.instr[F_SRC2_LO +: 3];
                    state_next    = DECODE;
                end
            end
            DECODE: begin
                aluop_next    = dec.aluop;
                operand1_next = sel_op1;
                operand2_next = sel_op2;
                if (dec.jump) begin
                    branch_next = 1'b1;
                    boff_next   = hi_reg;
                    state_next  = WB;
                end else begin
                    wait_next  = dec.long_wait ? ADD_WAIT_M1 : LOGIC_WAIT_M1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (wait_reg == 8'd0) begin
                    state_next = WB;
                    if (dec.illegal) begin
                        illegal_next = 1'b1;
                    end else if (dec.writes) begin
                        we_next        = 1'b1;
                        writereg_next  = hi_reg[2:0];
                        writedata_next = bus.result;
                    end else if (dec.cond_br && (bus.zero == dec.br_on_zero)) begin
                        branch_next = 1'b1;
                        boff_next   = hi_reg;
                    end
                end else begin
                    wait_next = wait_reg - 8'd1;
                end
            end
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase

        ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            op_reg        <= '0;
            hi_reg        <= '0;
            imm_reg       <= '0;
            wait_reg      <= '0;
            ready_reg     <= 1'b0;
            readreg1_reg  <= '0;
            readreg2_reg  <= '0;
            aluop_reg     <= '0;
            operand1_reg  <= '0;
            operand2_reg  <= '0;
            writereg_reg  <= '0;
            writedata_reg <= '0;
            we_reg        <= 1'b0;
            branch_reg    <= 1'b0;
            boff_reg      <= '0;
            illegal_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            op_reg        <= op_next;
            hi_reg        <= hi_next;
            imm_reg       <= imm_next;
            wait_reg      <= wait_next;
            ready_reg     <= ready_next;
            readreg1_reg  <= readreg1_next;
            readreg2_reg  <= readreg2_next;
            aluop_reg     <= aluop_next;
            operand1_reg  <= operand1_next;
            operand2_reg  <= operand2_next;
            writereg_reg  <= writereg_next;
            writedata_reg <= writedata_next;
            we_reg        <= we_next;
            branch_reg    <= branch_next;
            boff_reg      <= boff_next;
            illegal_reg   <= illegal_next;
        end
    end

    assign bus.instr_ready   = ready_reg;
    assign bus.readreg1      = readreg1_reg;
    assign bus.readreg2      = readreg2_reg;
    assign bus.aluop         = aluop_reg;
    assign bus.operand1      = operand1_reg;
    assign bus.operand2      = operand2_reg;
    assign bus.writereg      = writereg_reg;
    assign bus.writedata     = writedata_reg;
    assign bus.writeenable   = we_reg;
    assign bus.branch        = branch_reg;
    assign bus.branch_offset = boff_reg;
    assign bus.illegal       = illegal_reg;
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Bench for alu_ctrl_fsm: register file and ALU environment models plus an expected-result scoreboard.
module tb_alu_ctrl_fsm;
    import alu_ctrl_pkg::*;

    localparam int ADD_W = 2;
    localparam int LOG_W = 1;
`ifdef ALU_CTRL_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_ctrl_if bus();

    alu_ctrl_fsm #(.ADD_WAIT(ADD_W), .LOGIC_WAIT(LOG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Register file and ALU seen by the controller
    logic [7:0]  regs [8];
    logic [7:0]  alu_res;
    logic [15:0] rot;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (bus.writeenable) begin
            regs[bus.writereg] <= bus.writedata;
        end
    end
    assign bus.regout1 = regs[bus.readreg1];
    assign bus.regout2 = regs[bus.readreg2];

    always_comb begin
        rot = {bus.operand1, bus.operand1} >> bus.operand2[2:0];
        case (bus.aluop)
            3'd0: alu_res = bus.operand2;
            3'd1: alu_res = bus.operand1 + bus.operand2;
            3'd2: alu_res = bus.operand1 & bus.operand2;
            3'd3: alu_res = bus.operand1 | bus.operand2;
            3'd4: alu_res = bus.operand1 << bus.operand2[2:0];
            3'd5: alu_res = bus.operand1 >> bus.operand2[2:0];
            3'd6: alu_res = $signed(bus.operand1) >>> bus.operand2[2:0];
            default: alu_res = rot[7:0];
        endcase
    end
    assign bus.result = alu_res;
    assign bus.zero   = (alu_res == 8'h00);

    int cyc = 0;
    int accept_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst_n && bus.instr_ready && bus.instr_valid) accept_cnt <= accept_cnt + 1;

    // kind: 0 writeback, 1 branch, 2 illegal
    typedef struct {
        int         kind;
        logic [2:0] wreg;
        logic [7:0] wdata;
        logic [7:0] off;
        logic [2:0] aluop;
        logic [7:0] op2;
        bit         op2_chk;
        int         due;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] hi,
                                       input logic [2:0] s1, input logic [7:0] lo);
        return {op, hi, 5'b0, s1, lo};
    endfunction

    task automatic chk_reset(input string pfx);
        check({pfx, "_ready"},     bus.instr_ready,   0);
        check({pfx, "_aluop"},     bus.aluop,         0);
        check({pfx, "_operand1"},  bus.operand1,      0);
        check({pfx, "_operand2"},  bus.operand2,      0);
        check({pfx, "_readreg1"},  bus.readreg1,      0);
        check({pfx, "_readreg2"},  bus.readreg2,      0);
        check({pfx, "_writereg"},  bus.writereg,      0);
        check({pfx, "_writedata"}, bus.writedata,     0);
        check({pfx, "_we"},        bus.writeenable,   0);
        check({pfx, "_branch"},    bus.branch,        0);
        check({pfx, "_boff"},      bus.branch_offset, 0);
        check({pfx, "_illegal"},   bus.illegal,       0);
    endtask

    // Output monitor: pops one expectation per WB pulse
    initial begin
        bit   ready_chk;
        exp_t e;
        int   kind;
        ready_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ready_chk) begin
                    check("ready_after_wb", bus.instr_ready, 1);
                    ready_chk = 1'b0;
                end
                if (bus.writeenable || bus.branch || bus.illegal) begin
                    check("pulse_onehot", $countones({bus.writeenable, bus.branch, bus.illegal}), 1);
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", {bus.writeenable, bus.branch, bus.illegal}, 0);
                    end else begin
                        e = sb.pop_front();
                        kind = bus.writeenable ? 0 : (bus.branch ? 1 : 2);
                        $display("txn kind=%0d cyc=%0d wreg=%0d wdata=0x%02h boff=0x%02h aluop=%0d op2=0x%02h",
                                 kind, cyc, bus.writereg, bus.writedata, bus.branch_offset, bus.aluop, bus.operand2);
                        check("kind", kind, e.kind);
                        check("latency", cyc, e.due);
                        if (e.kind == 0) begin
                            check("writereg", bus.writereg, e.wreg);
                            check("writedata", bus.writedata, e.wdata);
                        end
                        if (e.kind == 1) check("branch_offset", bus.branch_offset, e.off);
                        if (e.kind == 2) check("illegal_aluop_msb", bus.aluop[2], 0);
                        else             check("aluop", bus.aluop, e.aluop);
                        if (e.op2_chk)   check("operand2", bus.operand2, e.op2);
                    end
                    ready_chk = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input bit hold, output int acc_cyc);
        exp_t       e;
        bit         push;
        int         n;
        int         lat;
        logic [7:0] op, a, b, imm, sr;
        logic [15:0] rr;
        acc_cyc = -1;
        n = 0;
        while (bus.instr_ready !== 1'b1) begin
            if (n >= 60) begin
                check("ready_timeout", bus.instr_ready, 1);
                return;
            end
            @(negedge clk);
            n++;
        end
        op  = ins[31:24];
        a   = regs[ins[10:8]];
        b   = regs[ins[2:0]];
        imm = ins[7:0];
        e.kind = 0; e.wreg = ins[18:16]; e.wdata = 8'h00; e.off = ins[23:16];
        e.aluop = 3'd0; e.op2 = b; e.op2_chk = 1'b1;
        push = 1'b1;
        lat = LOG_W + 1;
        case (op)
            8'd0: begin e.wdata = imm; e.op2 = imm; end
            8'd1: e.wdata = b;
            8'd2: begin e.wdata = a + b; e.aluop = 3'd1; lat = ADD_W + 1; end
            8'd3: begin e.wdata = a - b; e.aluop = 3'd1; e.op2 = 8'h00 - b; lat = ADD_W + 1; end
            8'd4: begin e.wdata = a & b; e.aluop = 3'd2; end
            8'd5: begin e.wdata = a | b; e.aluop = 3'd3; end
            8'd6: begin e.kind = 1; e.op2 = 8'h00; lat = 1; end
            8'd7, 8'd12: begin
                e.kind = 1; e.aluop = 3'd1; e.op2 = 8'h00 - b; lat = ADD_W + 1;
                push = (op == 8'd7) ? (a == b) : (a != b);
            end
            8'd8, 8'd9, 8'd10, 8'd11: begin
                if (SHIFT_EN) begin
                    e.aluop = {1'b1, op[1:0]};
                    e.op2 = imm;
                    rr = {a, a} >> imm[2:0];
                    sr = $signed(a) >>> imm[2:0];
                    case (op[1:0])
                        2'd0: e.wdata = a << imm[2:0];
                        2'd1: e.wdata = a >> imm[2:0];
                        2'd2: e.wdata = sr;
                        default: e.wdata = rr[7:0];
                    endcase
                end else begin
                    e.kind = 2; e.op2_chk = 1'b0;
                end
            end
            default: begin e.kind = 2; e.op2_chk = 1'b0; end
        endcase
        e.due = cyc + 1 + lat;
        if (push) sb.push_back(e);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        acc_cyc = cyc + 1;
        @(negedge clk);
        if (!hold) begin
            bus.instr_valid = 1'b0;
            bus.instr = $urandom;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.instr_ready !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int acc, a0, a1, a2, acc0;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        check("ready_before_edge", bus.instr_ready, 0);
        @(negedge clk);
        check("ready_after_release", bus.instr_ready, 1);

        issue(mk(8'd0, 8'd2, 3'd0, 8'h2A), 0, acc);
        wait_done();
        issue(mk(8'd0, 8'd1, 3'd0, 8'h05), 0, acc);
        issue(mk(8'd0, 8'd2, 3'd0, 8'h0A), 0, acc);
        issue(mk(8'd2, 8'd3, 3'd1, 8'd2), 0, acc);
        @(negedge clk) check("add_op2_exec1", bus.operand2, 8'h0A);
        @(negedge clk) check("add_op2_exec2", bus.operand2, 8'h0A);
        issue(mk(8'd0, 8'd4, 3'd0, 8'h01), 0, acc);
        issue(mk(8'd3, 8'd5, 3'd3, 8'd4), 0, acc);
        issue(mk(8'd7, 8'hFE, 3'd1, 8'd1), 0, acc);
        issue(mk(8'd7, 8'h10, 3'd1, 8'd2), 0, acc);
        issue(mk(8'd12, 8'h10, 3'd1, 8'd2), 0, acc);
        issue(mk(8'd12, 8'h44, 3'd2, 8'd2), 0, acc);
        issue(mk(8'd6, 8'h20, 3'd0, 8'd0), 0, acc);
        issue(mk(8'd4, 8'd6, 3'd3, 8'd4), 0, acc);
        issue(mk(8'd5, 8'd7, 3'd1, 8'd2), 0, acc);
        issue(mk(8'd1, 8'd6, 3'd0, 8'd2), 0, acc);
        issue(mk(8'd0, 8'd1, 3'd0, 8'h11), 0, acc);
        issue(mk(8'd8, 8'd1, 3'd1, 8'd3), 0, acc);
        issue(mk(8'd0, 8'd2, 3'd0, 8'h91), 0, acc);
        issue(mk(8'd10, 8'd3, 3'd2, 8'd2), 0, acc);
        issue(mk(8'd11, 8'd3, 3'd2, 8'd4), 0, acc);
        issue(mk(8'd0, 8'd4, 3'd0, 8'h80), 0, acc);
        issue(mk(8'd3, 8'd5, 3'd4, 8'd4), 0, acc);
        issue(mk(8'd0, 8'd4, 3'd0, 8'h00), 0, acc);
        issue(mk(8'd3, 8'd5, 3'd2, 8'd4), 0, acc);
        issue(mk(8'hFF, 8'h00, 3'd0, 8'h00), 0, acc);
        issue(mk(8'd13, 8'd1, 3'd1, 8'd1), 0, acc);
        wait_done();

        // INSTR_VALID held high: one accept per IDLE visit
        acc0 = accept_cnt;
        issue(mk(8'hFF, 8'h00, 3'd0, 8'h00), 1, a0);
        issue(mk(8'hFF, 8'h00, 3'd0, 8'h00), 1, a1);
        issue(mk(8'hFF, 8'h00, 3'd0, 8'h00), 0, a2);
        check("held_period1", a1 - a0, LOG_W + 3);
        check("held_period2", a2 - a1, LOG_W + 3);
        wait_done();
        check("held_accepts", accept_cnt - acc0, 3);

        // Reset during EXEC of add aborts without writeback
        issue(mk(8'd2, 8'd3, 3'd1, 8'd2), 0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_reset("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready_before_edge", bus.instr_ready, 0);
        @(negedge clk);
        check("abort_ready_after_release", bus.instr_ready, 1);
        repeat (4) @(negedge clk);
        issue(mk(8'd0, 8'd0, 3'd0, 8'h5A), 0, acc);
        wait_done();

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
